sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of word count (1024 x 32-bit words).
REQ-002 Parameter BASE_ADDR, default 32'h1c000000, byte address of word 0.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inst_sram_we  input  1  instruction port write enable; always ignored (read-only port).
REQ-006 inst_sram_addr  input  32  instruction port byte address.
REQ-007 inst_sram_wdata  input  32  instruction port write data; ignored.
REQ-008 inst_sram_rdata  output  32  instruction read data, registered.
REQ-009 data_sram_we  input  1  data port write enable.
REQ-010 data_sram_addr  input  32  data port byte address.
REQ-011 data_sram_wdata  input  32  data port write data.
REQ-012 data_sram_rdata  output  32  data read data, registered.
REQ-013 ready  output  1  1 = memory initialised and servicing requests.
REQ-014 inst_err  output  1  registered; previous-cycle instruction address was illegal.
REQ-015 data_err  output  1  registered; previous-cycle data address was illegal.
REQ-016 wr_count  output  32  number of committed data writes, saturating at 32'hffffffff.

Function
REQ-017 The module SHALL implement two states, CLEAR and RUN, with CLEAR entered on reset.
REQ-018 In CLEAR, the module SHALL write 0 to one word per cycle, index 0 up to DEPTH-1, using a DEPTH_LOG2-bit counter.
REQ-019 The module SHALL move from CLEAR to RUN in the cycle after it writes index DEPTH-1, so CLEAR lasts exactly 2^DEPTH_LOG2 cycles.
REQ-020 ready SHALL be 0 in CLEAR and 1 in RUN.
REQ-021 In CLEAR, both ports SHALL ignore requests, both rdata outputs SHALL be held at 0, and both err flags SHALL be held at 0.
REQ-022 Address offset off = addr - BASE_ADDR (32-bit wrap-around subtraction), and index = off[DEPTH_LOG2+1:2].
REQ-023 An address SHALL be legal only when off[1:0] == 0 and off < 4*2^DEPTH_LOG2.
REQ-024 In RUN, each port SHALL read every cycle with 1-cycle latency: rdata in cycle N+1 = word at the cycle-N index.
REQ-025 For an illegal address in cycle N, rdata SHALL be 0 and err SHALL be 1 in cycle N+1; err SHALL be 0 for a legal address.
REQ-026 In RUN, a data write SHALL commit when data_sram_we = 1 and the address is legal.
REQ-027 An illegal-address write SHALL be dropped, SHALL not change memory, and SHALL not increment wr_count.
REQ-028 Write-first ordering: a data-port read and a data-port write to the same index in the same cycle SHALL return the new wdata next cycle.
REQ-029 Write-first ordering: an inst-port read of the index written by the data port in the same cycle SHALL return the new wdata next cycle.
REQ-030 Reads of different indices in the same cycle SHALL be independent.
REQ-031 wr_count SHALL increment by 1 per committed write and SHALL stay at 32'hffffffff once reached.
REQ-032 inst_sram_we and inst_sram_wdata SHALL have no effect on memory, counters or outputs.

Reset
REQ-033 While reset = 1 at posedge, outputs SHALL become: inst_sram_rdata = 0, data_sram_rdata = 0, ready = 0, inst_err = 0, data_err = 0, wr_count = 0.
REQ-034 While reset = 1 at posedge, the state SHALL become CLEAR and the clear counter SHALL become 0.
REQ-035 Reset asserted mid-RUN or mid-CLEAR SHALL abort any pending write in that cycle and SHALL restart the full clear sequence.
REQ-036 Memory contents SHALL be all zero when ready first rises after reset.

Verification (DEPTH_LOG2 = 4 for the bench unless stated)
REQ-037 Reset 1 cycle, then idle -> ready = 0 for exactly 16 cycles, then 1; reading 0x1c00003c returns 0.
REQ-038 Write 0xdeadbeef to 0x1c000008 with inst_sram_addr = 0x1c000008 in the same cycle -> next cycle inst_sram_rdata = data_sram_rdata = 0xdeadbeef, wr_count = 1.
REQ-039 Write 0x1234 to 0x1c000041 (misaligned), then write to 0x1c000040 (beyond 16 words) -> data_err = 1 on each following cycle, wr_count unchanged, all words still 0.
REQ-040 Write index 3 with 0xa5a5a5a5, then assert reset for 1 cycle -> ready = 0 for 16 cycles, then a read of index 3 returns 0 and wr_count = 0.
REQ-041 Assert inst_sram_we = 1 with inst_sram_wdata = 0xffffffff at 0x1c000000 -> memory is unchanged, inst_sram_rdata = 0, wr_count = 0.
REQ-042 Force wr_count to 32'hfffffffe, then do 3 legal writes -> wr_count = 32'hffffffff and stays there.

Source files
------------

// File: rtl/sram_responder.sv
// ---------------------------------------------------------------------------
// sram_responder
//   Single-cycle-latency SRAM model with a read-only instruction port and a
//   read/write data port sharing one word array. After reset the array is
//   zeroed one word per cycle (CLEAR). Requests are served only in RUN.
//
// Parameters
//   DEPTH_LOG2 : log2 of the number of 32-bit words (at most 29)
//   BASE_ADDR  : byte address of word 0
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   inst_sram_we      : instruction write enable (ignored, read-only port)
//   inst_sram_addr    : instruction byte address
//   inst_sram_wdata   : instruction write data (ignored)
//   inst_sram_rdata   : registered instruction read data
//   data_sram_we      : data write enable
//   data_sram_addr    : data byte address
//   data_sram_wdata   : data write data
//   data_sram_rdata   : registered data read data
//   ready             : 1 once the array is cleared and requests are served
//   inst_err/data_err : previous-cycle address on that port was illegal
//   wr_count          : committed data writes, saturating at all ones
// ---------------------------------------------------------------------------
module sram_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        ready,
    output logic        inst_err,
    output logic        data_err,
    output logic [31:0] wr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] clr_idx;
    logic [31:0]           mem [DEPTH];

    logic [31:0]           i_off, d_off;
    logic [DEPTH_LOG2-1:0] i_idx, d_idx;
    logic                  i_legal, d_legal;
    logic                  d_commit;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic [31:0]           mem_wdata;
    logic [31:0]           i_word, d_word;

    // The instruction port is read-only; its write inputs are deliberately unused.
    logic unused_inst_wr;
    assign unused_inst_wr = ^{inst_sram_we, inst_sram_wdata};

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign i_off = inst_sram_addr - BASE_ADDR;
    assign d_off = data_sram_addr - BASE_ADDR;
    assign i_idx = i_off[DEPTH_LOG2+1:2];
    assign d_idx = d_off[DEPTH_LOG2+1:2];

    // Legal: word aligned and every bit above the index field is zero.
    assign i_legal = (i_off[1:0] == 2'b00) && (i_off[31:DEPTH_LOG2+2] == '0);
    assign d_legal = (d_off[1:0] == 2'b00) && (d_off[31:DEPTH_LOG2+2] == '0);

    assign d_commit = (state == RUN) && data_sram_we && d_legal;

    // One write port: the clear sweep in CLEAR, committed data writes in RUN.
    // A reset cycle drops whatever write was pending.
    assign mem_we    = !reset && ((state == CLEAR) || d_commit);
    assign mem_widx  = (state == CLEAR) ? clr_idx : d_idx;
    assign mem_wdata = (state == CLEAR) ? 32'h0 : data_sram_wdata;

    // Write-first: a same-cycle write to the index being read is forwarded.
    assign i_word = (d_commit && (d_idx == i_idx)) ? data_sram_wdata : mem[i_idx];
    assign d_word = d_commit ? data_sram_wdata : mem[d_idx];

    // NOTE: the array has no reset term; zeroing is done by the CLEAR sweep so
    // it can map onto RAM that has no bulk-reset capability.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // NOTE: all registered state uses non-blocking assignments so every
    // reader sees the pre-edge value regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= CLEAR;
            clr_idx         <= '0;
            ready           <= 1'b0;
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
            inst_err        <= 1'b0;
            data_err        <= 1'b0;
            wr_count        <= 32'h0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx         <= clr_idx + 1'b1;
                    inst_sram_rdata <= 32'h0;
                    data_sram_rdata <= 32'h0;
                    inst_err        <= 1'b0;
                    data_err        <= 1'b0;
                    if (&clr_idx) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    inst_sram_rdata <= i_legal ? i_word : 32'h0;
                    data_sram_rdata <= d_legal ? d_word : 32'h0;
                    inst_err        <= !i_legal;
                    data_err        <= !d_legal;
                    if (d_commit && (wr_count != 32'hffffffff)) begin
                        wr_count <= wr_count + 32'd1;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_sram_responder
//   Self-checking bench for sram_responder with DEPTH_LOG2 = 4 (16 words).
//   Table-driven vectors carry inputs and hand-computed expected outputs;
//   expected records are queued when a vector is driven and compared when
//   the DUT produces its registered response one cycle later.
// ---------------------------------------------------------------------------
module tb_sram_responder;

    localparam logic [31:0] B = 32'h1c000000;

    logic        clk;
    logic        reset;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        ready;
    logic        inst_err;
    logic        data_err;
    logic [31:0] wr_count;

    sram_responder #(
        .DEPTH_LOG2(4),
        .BASE_ADDR (B)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_we   (data_sram_we),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .ready          (ready),
        .inst_err       (inst_err),
        .data_err       (data_err),
        .wr_count       (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] i_addr;
        logic        i_we;
        logic [31:0] i_wdata;
    } stim_t;

    typedef struct {
        logic [31:0] i_rdata;
        logic [31:0] d_rdata;
        logic        i_err;
        logic        d_err;
        logic [31:0] wrc;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic d_we, input logic [31:0] d_addr,
                                input logic [31:0] d_wdata, input logic [31:0] i_addr,
                                input logic i_we, input logic [31:0] i_wdata,
                                input logic [31:0] e_i, input logic [31:0] e_d,
                                input logic e_ie, input logic e_de, input logic [31:0] e_wrc);
        vec_t v;
        v.s.d_we    = d_we;
        v.s.d_addr  = d_addr;
        v.s.d_wdata = d_wdata;
        v.s.i_addr  = i_addr;
        v.s.i_we    = i_we;
        v.s.i_wdata = i_wdata;
        v.e.i_rdata = e_i;
        v.e.d_rdata = e_d;
        v.e.i_err   = e_ie;
        v.e.d_err   = e_de;
        v.e.wrc     = e_wrc;
        return v;
    endfunction

    task automatic drive_idle();
        data_sram_we    = 1'b0;
        data_sram_addr  = B;
        data_sram_wdata = 32'h0;
        inst_sram_we    = 1'b0;
        inst_sram_addr  = B;
        inst_sram_wdata = 32'h0;
    endtask

    // Drive one vector in RUN, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        data_sram_we    = v.s.d_we;
        data_sram_addr  = v.s.d_addr;
        data_sram_wdata = v.s.d_wdata;
        inst_sram_we    = v.s.i_we;
        inst_sram_addr  = v.s.i_addr;
        inst_sram_wdata = v.s.i_wdata;
        sb_q.push_back(v.e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, ".ready"},    {31'b0, ready},    32'd1);
        check({tag, ".i_rdata"},  inst_sram_rdata,   e.i_rdata);
        check({tag, ".d_rdata"},  data_sram_rdata,   e.d_rdata);
        check({tag, ".i_err"},    {31'b0, inst_err}, {31'b0, e.i_err});
        check({tag, ".d_err"},    {31'b0, data_err}, {31'b0, e.d_err});
        check({tag, ".wr_count"}, wr_count,          e.wrc);
    endtask

    // One reset cycle with a legal data write pending, which must be dropped.
    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        data_sram_we    = 1'b1;
        data_sram_addr  = B + 32'h0c;
        data_sram_wdata = 32'ha5a5a5a5;
        @(posedge clk);
        #1;
        check("rst.ready",    {31'b0, ready},    32'd0);
        check("rst.i_rdata",  inst_sram_rdata,   32'd0);
        check("rst.d_rdata",  data_sram_rdata,   32'd0);
        check("rst.i_err",    {31'b0, inst_err}, 32'd0);
        check("rst.d_err",    {31'b0, data_err}, 32'd0);
        check("rst.wr_count", wr_count,          32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
    endtask

    // Count cycles with ready low (including the one after the reset edge).
    // Requests driven meanwhile must be ignored and outputs held at zero.
    task automatic count_clear(input string tag);
        int cnt = 1;
        data_sram_we    = 1'b1;
        data_sram_addr  = B + 32'h04;
        data_sram_wdata = 32'h00000055;
        inst_sram_addr  = B + 32'h41;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (ready) break;
            cnt++;
            if (k == 7) begin
                check({tag, ".clr_d_rdata"}, data_sram_rdata,   32'd0);
                check({tag, ".clr_i_err"},   {31'b0, inst_err}, 32'd0);
            end
        end
        check({tag, ".clear_len"}, cnt, 32'd16);
    endtask

    vec_t tv[13];

    initial begin
        // Expected values start from an all-zero array after the clear.
        tv[0]  = mk(0, B+32'h04, 0,            B+32'h3c, 0, 0,            32'h0,        32'h0,        0, 0, 32'd0);
        tv[1]  = mk(1, B+32'h08, 32'hdeadbeef, B+32'h08, 0, 0,            32'hdeadbeef, 32'hdeadbeef, 0, 0, 32'd1);
        tv[2]  = mk(0, B+32'h08, 0,            B+32'h00, 0, 0,            32'h0,        32'hdeadbeef, 0, 0, 32'd1);
        tv[3]  = mk(1, B+32'h41, 32'h1234,     B+32'h08, 0, 0,            32'hdeadbeef, 32'h0,        0, 1, 32'd1);
        tv[4]  = mk(1, B+32'h40, 32'h1234,     B+32'h40, 0, 0,            32'h0,        32'h0,        1, 1, 32'd1);
        tv[5]  = mk(0, B+32'h00, 0,            B+32'h04, 0, 0,            32'h0,        32'h0,        0, 0, 32'd1);
        tv[6]  = mk(0, B-32'h04, 0,            B+32'h3c, 0, 0,            32'h0,        32'h0,        0, 1, 32'd1);
        tv[7]  = mk(0, B+32'h00, 0,            B+32'h00, 1, 32'hffffffff, 32'h0,        32'h0,        0, 0, 32'd1);
        tv[8]  = mk(0, B+32'h00, 0,            B+32'h00, 0, 0,            32'h0,        32'h0,        0, 0, 32'd1);
        tv[9]  = mk(1, B+32'h14, 32'h11111111, B+32'h08, 0, 0,            32'hdeadbeef, 32'h11111111, 0, 0, 32'd2);
        tv[10] = mk(1, B+32'h3c, 32'hcafef00d, B+32'h14, 0, 0,            32'h11111111, 32'hcafef00d, 0, 0, 32'd3);
        tv[11] = mk(0, B+32'h14, 0,            B+32'h3c, 0, 0,            32'hcafef00d, 32'h11111111, 0, 0, 32'd3);
        tv[12] = mk(1, B+32'h0c, 32'ha5a5a5a5, B+32'h0c, 0, 0,            32'ha5a5a5a5, 32'ha5a5a5a5, 0, 0, 32'd4);

        reset = 1'b0;
        drive_idle();

        // Power-up clear, then the main vector table.
        do_reset();
        count_clear("init");
        for (int i = 0; i < 13; i++) begin
            apply(tv[i], $sformatf("tv%0d", i));
        end

        // Reset from RUN: full clear again, array and counter back to zero.
        do_reset();
        count_clear("run_rst");
        apply(mk(0, B+32'h0c, 0, B+32'h08, 0, 0, 32'h0, 32'h0, 0, 0, 32'd0), "post_rst");
        apply(mk(0, B+32'h3c, 0, B+32'h14, 0, 0, 32'h0, 32'h0, 0, 0, 32'd0), "post_rst2");

        // Reset in the middle of CLEAR restarts the full sweep.
        do_reset();
        repeat (5) @(posedge clk);
        do_reset();
        count_clear("mid_clr");

        // Saturation of wr_count from a forced near-max value.
        @(negedge clk);
        force dut.wr_count = 32'hfffffffe;
        #1;
        release dut.wr_count;
        apply(mk(1, B+32'h04, 32'h1, B+32'h00, 0, 0, 32'h0, 32'h1, 0, 0, 32'hffffffff), "sat1");
        apply(mk(1, B+32'h08, 32'h2, B+32'h04, 0, 0, 32'h1, 32'h2, 0, 0, 32'hffffffff), "sat2");
        apply(mk(1, B+32'h0c, 32'h3, B+32'h08, 0, 0, 32'h2, 32'h3, 0, 0, 32'hffffffff), "sat3");
        apply(mk(0, B+32'h0c, 0,     B+32'h04, 0, 0, 32'h1, 32'h3, 0, 0, 32'hffffffff), "sat_hold");

        check("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
